sync_fifo_lvl: RTL and testbench
================================

SYNC_FIFO_LVL -- requirements
Module: sync_fifo_lvl

Interface
REQ-001 SHALL have parameter DEPTH, default 32: entry count, power of two, >= 2.
REQ-002 SHALL have parameter DWIDTH, default 8: data width in bits.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2: afull_o asserts when level >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2: aempty_o asserts when level <= AEMPTY_TH.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; port list follows:
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 clr_i  input  1  synchronous flush.
REQ-009 wenc_i  input  1  write request.
REQ-010 wdata_i  input  DWIDTH  write data.
REQ-011 renc_i  input  1  read request.
REQ-012 rdata_o  output  DWIDTH  read data.
REQ-013 rvalid_o  output  1  rdata_o valid.
REQ-014 full_o / empty_o  output  1 each  level==DEPTH / level==0.
REQ-015 afull_o / aempty_o  output  1 each  threshold flags.
REQ-016 level_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 ovf_o / udf_o  output  1 each  sticky overflow / underflow errors.

Function
REQ-018 SHALL accept a write on a rising edge when wenc_i=1 and full_o=0; data is stored at wptr and wptr increments modulo DEPTH.
REQ-019 SHALL accept a read when renc_i=1 and empty_o=0; rptr increments modulo DEPTH.
REQ-020 Flags SHALL use registered state only: a write when full is rejected even if a read is accepted in the same cycle, and a read when empty is rejected even if a write is accepted in the same cycle.
REQ-021 level_o SHALL update each cycle as follows: +1 on write only, -1 on read only, unchanged on both or neither; it never exceeds DEPTH and never wraps.
REQ-022 full_o, empty_o, afull_o and aempty_o SHALL be decoded combinationally from registered level_o, so they take effect the cycle after the causing write or read.
REQ-023 ovf_o SHALL set and hold when wenc_i=1 while full_o=1; udf_o SHALL set and hold when renc_i=1 while empty_o=1; neither alters pointers or data.
REQ-024 clr_i=1 SHALL, at the next edge, zero wptr, rptr and level, clear ovf_o, udf_o and rvalid_o, and ignore any concurrent read or write; RAM contents are not cleared.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no loss or duplication across any number of wraps.

Reset
REQ-026 While rst_n=0, and immediately on its assertion, the block SHALL drive: wptr=rptr=0, level_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, ovf_o=0, udf_o=0, rvalid_o=0, rdata_o=0.
REQ-027 Reset mid-operation SHALL discard all stored entries; the first accepted read after release returns the first write made after release.
REQ-028 RAM storage SHALL NOT be reset.

Configuration
REQ-029 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; rdata_o SHALL show the entry at rptr combinationally, rvalid_o=!empty_o, and an accepted read advances to the next entry in the same cycle.
REQ-030 Macro SYNC_FIFO_FWFT_EN undefined: registered read; an accepted read SHALL load rdata_o on that edge and pulse rvalid_o for exactly one cycle; rdata_o holds its value otherwise.

Verification (DEPTH=4, DWIDTH=8, AFULL_TH=3, AEMPTY_TH=1)
REQ-031 Write 0x11,0x22,0x33,0x44 on consecutive cycles, then read 4 -> level_o goes 1,2,3,4 with afull_o set at 3 and full_o at 4; reads return 0x11..0x44 in order; empty_o=1 at the end.
REQ-032 Fill to 4, then drive wenc_i=renc_i=1 with 0x55 -> read accepted, write rejected, level_o=3, ovf_o=1; then clr_i=1 for one cycle -> level_o=0, ovf_o=0.
REQ-033 Empty FIFO with wenc_i=renc_i=1, data 0xA5 -> write accepted, read rejected, udf_o=1, level_o=1; next read returns 0xA5.
REQ-034 Stream 10 writes of 0x00..0x09 with interleaved reads keeping level_o in 1..3 -> all 10 values read in order across pointer wrap, with no ovf_o or udf_o.
REQ-035 Write 0x77 and 0x88, assert rst_n=0 mid-cycle, release, then write 0x99 and read -> outputs take reset values immediately and the read returns 0x99.
REQ-036 Run REQ-031 with and without SYNC_FIFO_FWFT_EN -> with it, rdata_o=0x11 and rvalid_o=1 one cycle after the first write; without it, rdata_o=0x11 with a one-cycle rvalid_o pulse on the cycle after the first read.

Source files
------------

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with occupancy level and status flags.
// Storage is a flat array; flags decode from the registered level only.
//
// Optional build macro:
//   SYNC_FIFO_FWFT_EN  first-word-fall-through read port. When undefined
//                      the read port is registered (one-cycle rvalid_o).
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr_i      synchronous flush of pointers, level and error flags
//   wenc_i     write request, accepted when not full
//   wdata_i    write data
//   renc_i     read request, accepted when not empty
//   rdata_o    read data
//   rvalid_o   rdata_o valid
//   full_o     level == DEPTH
//   empty_o    level == 0
//   afull_o    level >= AFULL_TH
//   aempty_o   level <= AEMPTY_TH
//   level_o    current occupancy, 0..DEPTH
//   ovf_o      sticky: write requested while full
//   udf_o      sticky: read requested while empty

module sync_fifo_lvl #(
    parameter int DEPTH     = 32,
    parameter int DWIDTH    = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   wenc_i,
    input  logic [DWIDTH-1:0]      wdata_i,
    input  logic                   renc_i,
    output logic [DWIDTH-1:0]      rdata_o,
    output logic                   rvalid_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   afull_o,
    output logic                   aempty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   ovf_o,
    output logic                   udf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_TH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_TH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          udf_q;

    logic          wr_ok;
    logic          rd_ok;

    // Flags come only from the registered level, so a same-cycle
    // read never makes room for a write into a full FIFO and a
    // same-cycle write never feeds a read from an empty one.
    assign full_o   = (level_q == LVL_FULL);
    assign empty_o  = (level_q == '0);
    assign afull_o  = (level_q >= LVL_AF);
    assign aempty_o = (level_q <= LVL_AE);
    assign level_o  = level_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

    assign wr_ok = wenc_i & ~full_o;
    assign rd_ok = renc_i & ~empty_o;

    // Pointers, level and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            // Power-of-two depth: pointer wrap is the natural
            // overflow of the AW-bit add.
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (wenc_i && full_o) begin
                ovf_q <= 1'b1;
            end
            if (renc_i && empty_o) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; stale words are unreachable once
    // the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr_i) begin
            mem[wptr_q] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN

    // Head entry is always presented; forcing zero while empty
    // keeps rdata_o at its reset value and hides stale storage.
    assign rdata_o  = empty_o ? '0 : mem[rptr_q];
    assign rvalid_o = ~empty_o;

`else

    logic [DWIDTH-1:0] rdata_q;
    logic              rvalid_q;

    // Registered read: data lands on the accepting edge and
    // is held until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (clr_i) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
            if (rd_ok) begin
                rdata_q <= mem[rptr_q];
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: table vectors plus a queue model for sync_fifo_lvl.
// DEPTH=4, DWIDTH=8, AFULL_TH=3, AEMPTY_TH=1.

module tb_sync_fifo_lvl;

    localparam int D   = 4;
    localparam int AFT = 3;
    localparam int AET = 1;

    logic       clk;
    logic       rst_n;
    logic       clr_i;
    logic       wenc_i;
    logic [7:0] wdata_i;
    logic       renc_i;
    logic [7:0] rdata_o;
    logic       rvalid_o;
    logic       full_o;
    logic       empty_o;
    logic       afull_o;
    logic       aempty_o;
    logic [2:0] level_o;
    logic       ovf_o;
    logic       udf_o;

    sync_fifo_lvl #(
        .DEPTH    (D),
        .DWIDTH   (8),
        .AFULL_TH (AFT),
        .AEMPTY_TH(AET)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr_i),
        .wenc_i  (wenc_i),
        .wdata_i (wdata_i),
        .renc_i  (renc_i),
        .rdata_o (rdata_o),
        .rvalid_o(rvalid_o),
        .full_o  (full_o),
        .empty_o (empty_o),
        .afull_o (afull_o),
        .aempty_o(aempty_o),
        .level_o (level_o),
        .ovf_o   (ovf_o),
        .udf_o   (udf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_rd;
    logic       m_ovf;
    logic       m_udf;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
        logic [2:0] lvl;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_state();
        int n;
        n = q.size();
        chk("level", 32'(level_o), 32'(n));
        chk("full", 32'(full_o), 32'(n == D));
        chk("empty", 32'(empty_o), 32'(n == 0));
        chk("afull", 32'(afull_o), 32'(n >= AFT));
        chk("aempty", 32'(aempty_o), 32'(n <= AET));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
        chk("udf", 32'(udf_o), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_rvalid", 32'(rvalid_o), 32'(n != 0));
        chk("fwft_head", 32'(rdata_o), 32'((n != 0) ? q[0] : 8'h00));
`endif
    endtask

    task automatic cyc(input logic w, input logic [7:0] d,
                       input logic r, input logic c);
        logic       full_m;
        logic       empty_m;
        logic       wr_ok;
        logic       rd_ok;
        logic [7:0] e;
        wenc_i  = w;
        wdata_i = d;
        renc_i  = r;
        clr_i   = c;
        full_m  = (q.size() == D);
        empty_m = (q.size() == 0);
        wr_ok   = w && !full_m && !c;
        rd_ok   = r && !empty_m && !c;
        if (rd_ok) exp_q.push_back(q[0]);
`ifdef SYNC_FIFO_FWFT_EN
        #1;
        if (rd_ok) begin
            e = exp_q.pop_front();
            chk("fwft_rd", 32'(rdata_o), 32'(e));
        end
`endif
        @(posedge clk);
        #1;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && full_m) m_ovf = 1'b1;
            if (r && empty_m) m_udf = 1'b1;
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
        end
`ifndef SYNC_FIFO_FWFT_EN
        chk("rvalid", 32'(rvalid_o), 32'(rd_ok));
        if (rd_ok) begin
            e = exp_q.pop_front();
            chk("rdata", 32'(rdata_o), 32'(e));
            last_rd = e;
        end else begin
            chk("rdata_hold", 32'(rdata_o), 32'(last_rd));
        end
`endif
        wenc_i = 1'b0;
        renc_i = 1'b0;
        clr_i  = 1'b0;
        chk_state();
    endtask

    function automatic vec_t mk(logic w, logic [7:0] d, logic r,
                                logic c, logic [2:0] lvl,
                                logic ovf, logic udf);
        vec_t v;
        v.w = w;   v.d = d;     v.r = r;   v.c = c;
        v.lvl = lvl; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk_reset_vals();
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_aempty", 32'(aempty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_afull", 32'(afull_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_udf", 32'(udf_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        clr_i   = 1'b0;
        wenc_i  = 1'b0;
        wdata_i = 8'h00;
        renc_i  = 1'b0;
        last_rd = 8'h00;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;

        // fill, drain, thresholds
        tbl.push_back(mk(1, 8'h11, 0, 0, 3'd1, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 3'd2, 0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 0, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h44, 0, 0, 3'd4, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'd3, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'd2, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'd1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'd0, 0, 0));
        // write+read at full, then flush
        tbl.push_back(mk(1, 8'h01, 0, 0, 3'd1, 0, 0));
        tbl.push_back(mk(1, 8'h02, 0, 0, 3'd2, 0, 0));
        tbl.push_back(mk(1, 8'h03, 0, 0, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h04, 0, 0, 3'd4, 0, 0));
        tbl.push_back(mk(1, 8'h55, 1, 0, 3'd3, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3'd0, 0, 0));
        // write+read at empty
        tbl.push_back(mk(1, 8'hA5, 1, 0, 3'd1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'd0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3'd0, 0, 0));
        // lone read at empty, lone write at full
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'd0, 0, 1));
        tbl.push_back(mk(1, 8'hC1, 0, 0, 3'd1, 0, 1));
        tbl.push_back(mk(1, 8'hC2, 0, 0, 3'd2, 0, 1));
        tbl.push_back(mk(1, 8'hC3, 0, 0, 3'd3, 0, 1));
        tbl.push_back(mk(1, 8'hC4, 0, 0, 3'd4, 0, 1));
        tbl.push_back(mk(1, 8'hEE, 0, 0, 3'd4, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3'd3, 1, 1));
        tbl.push_back(mk(1, 8'hC5, 1, 1, 3'd0, 0, 0));

        #12;
        chk_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            cyc(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            chk($sformatf("tbl%0d_level", i), 32'(level_o),
                32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf_o),
                32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_udf", i), 32'(udf_o),
                32'(tbl[i].udf));
        end

        // streaming across several pointer wraps, level kept 1..3
        cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h01, 0, 0);
        for (int i = 2; i < 10; i++) begin
            cyc(1, 8'(i), 1, 0);
            chk("stream_level", 32'(level_o), 32'd2);
        end
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("stream_ovf", 32'(ovf_o), 32'd0);
        chk("stream_udf", 32'(udf_o), 32'd0);

        // reset mid-operation
        cyc(1, 8'h77, 0, 0);
        cyc(1, 8'h88, 0, 0);
        cyc(0, 8'h00, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        q.delete();
        exp_q.delete();
        last_rd = 8'h00;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 8'h99, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        chk("post_rst_last", 32'(last_rd), 32'(8'h99));

        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
